// File: rtl/issue_age_select.sv
// Free-slot allocator and oldest-first select scheduler for the issue queue.
// Relative age lives in a pairwise matrix, so order survives out-of-order frees.
module issue_age_select #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic               alloc_req,
  output logic               alloc_ack,
  output logic [IDX_W-1:0]   alloc_idx,
  input  logic [ENTRIES-1:0] ready_vec,
  output logic               issue_valid,
  output logic [IDX_W-1:0]   issue_idx,
  input  logic               exe_ready,
  output logic [4:0]         free_count,
  output logic               queue_full,
  output logic               queue_empty
);

  localparam logic [4:0] ALL_FREE = 5'(ENTRIES);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                           state;
  logic [ENTRIES-1:0]               valid;
  logic [ENTRIES-1:0]               inflight;
  logic [ENTRIES-1:0][ENTRIES-1:0]  older;
  logic [ENTRIES-1:0]               cand;
  logic [IDX_W-1:0]                 sel_idx;
  logic                             sel_any;
  logic                             accept;
  logic                             blocked;

  assign queue_full  = (free_count == '0);
  assign queue_empty = (free_count == ALL_FREE);
  assign alloc_ack   = alloc_req & ~queue_full & ~STALL & ~FLUSH;
  assign cand        = valid & ready_vec & ~inflight;
  assign sel_any     = |cand;
  assign accept      = (state == OFFER) & exe_ready;

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) alloc_idx = IDX_W'(i);
  end

  // A candidate is the oldest when no other candidate is marked older than it.
  always_comb begin
    sel_idx = '0;
    blocked = 1'b0;
    for (int c = ENTRIES - 1; c >= 0; c--) begin
      blocked = 1'b0;
      for (int k = 0; k < ENTRIES; k++)
        blocked = blocked | (cand[k] & older[k][c]);
      if (cand[c] && !blocked) sel_idx = IDX_W'(c);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid       <= '0;
      inflight    <= '0;
      older       <= '0;
      state       <= IDLE;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      free_count  <= ALL_FREE;
    end else if (FLUSH) begin
      valid       <= '0;
      inflight    <= '0;
      older       <= '0;
      state       <= IDLE;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      free_count  <= ALL_FREE;
    end else if (!STALL) begin
      // New slot becomes the youngest; the freed-slot clear below wins on overlap.
      if (alloc_ack) begin
        valid[alloc_idx] <= 1'b1;
        for (int k = 0; k < ENTRIES; k++) begin
          older[k][alloc_idx] <= valid[k];
          older[alloc_idx][k] <= 1'b0;
        end
      end
      if (accept) begin
        valid[issue_idx]    <= 1'b0;
        inflight[issue_idx] <= 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
          older[issue_idx][k] <= 1'b0;
          older[k][issue_idx] <= 1'b0;
        end
      end
      free_count <= free_count - 5'(alloc_ack) + 5'(accept);
      case (state)
        IDLE: begin
          if (sel_any) begin
            issue_idx         <= sel_idx;
            issue_valid       <= 1'b1;
            inflight[sel_idx] <= 1'b1;
            state             <= OFFER;
          end
        end
        OFFER: begin
          // The offered slot is already inflight, so sel_idx never re-picks it.
          if (exe_ready) begin
            if (sel_any) begin
              issue_idx         <= sel_idx;
              inflight[sel_idx] <= 1'b1;
            end else begin
              issue_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_age_select.sv
// Directed bench for issue_age_select with an allocation-order queue model
// checked on every falling clock edge.
module tb_issue_age_select;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               STALL = 1'b0;
  logic               FLUSH = 1'b0;
  logic               alloc_req = 1'b0;
  logic               exe_ready = 1'b0;
  logic [ENTRIES-1:0] ready_vec = '0;
  logic               alloc_ack;
  logic [IDX_W-1:0]   alloc_idx;
  logic               issue_valid;
  logic [IDX_W-1:0]   issue_idx;
  logic [4:0]         free_count;
  logic               queue_full;
  logic               queue_empty;

  int n_cmp = 0;
  int n_bad = 0;

  issue_age_select #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_idx(alloc_idx),
    .ready_vec(ready_vec), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .exe_ready(exe_ready), .free_count(free_count),
    .queue_full(queue_full), .queue_empty(queue_empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: occupied slots held oldest-first in allocation order.
  int m_order[$];
  bit m_offv = 1'b0;
  int m_offi = 0;
  int m_oldest;
  int m_aidx;
  int m_pos;
  bit m_ack;
  bit m_acc;

  function automatic bit m_has(int s);
    foreach (m_order[i]) if (m_order[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_lowest_free();
    for (int s = 0; s < ENTRIES; s++) if (!m_has(s)) return s;
    return 0;
  endfunction

  always @(negedge RESET) begin
    m_order.delete();
    m_offv = 1'b0;
  end

  always @(posedge CLK) begin
    if (!RESET || FLUSH) begin
      m_order.delete();
      m_offv = 1'b0;
    end else if (!STALL) begin
      m_ack    = alloc_req && (m_order.size() < ENTRIES);
      m_aidx   = m_lowest_free();
      m_oldest = -1;
      foreach (m_order[i])
        if (m_oldest < 0 && ready_vec[m_order[i]] && !(m_offv && m_order[i] == m_offi))
          m_oldest = m_order[i];
      m_acc = m_offv && exe_ready;
      if (m_acc) begin
        m_pos = -1;
        foreach (m_order[i]) if (m_order[i] == m_offi) m_pos = i;
        if (m_pos >= 0) m_order.delete(m_pos);
      end
      if (m_ack) m_order.push_back(m_aidx);
      if (!m_offv || m_acc) begin
        if (m_oldest >= 0) begin
          m_offv = 1'b1;
          m_offi = m_oldest;
        end else begin
          m_offv = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("m_alloc_ack", alloc_ack,
        alloc_req && (m_order.size() < ENTRIES) && !STALL && !FLUSH);
    chk("m_alloc_idx", alloc_idx, m_lowest_free());
    chk("m_free_count", free_count, ENTRIES - m_order.size());
    chk("m_queue_full", queue_full, m_order.size() == ENTRIES);
    chk("m_queue_empty", queue_empty, m_order.size() == 0);
    chk("m_issue_valid", issue_valid, m_offv);
    if (m_offv) chk("m_issue_idx", issue_idx, m_offi);
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset sequence
    step(3);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_free_count", free_count, 16);
    chk("rst_queue_empty", queue_empty, 1);
    chk("rst_queue_full", queue_full, 0);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_alloc_ack", alloc_ack, 0);
    RESET = 1'b1;
    step(2);
    chk("post_rst_issue_valid", issue_valid, 0);
    chk("post_rst_free_count", free_count, 16);
    chk("post_rst_alloc_idx", alloc_idx, 0);

    // Fill all slots, then one more request at full
    for (int i = 0; i < 17; i++) begin
      alloc_req = 1'b1;
      #1;
      chk("fill_alloc_idx", alloc_idx, (i < 16) ? i : 0);
      chk("fill_alloc_ack", alloc_ack, (i < 16) ? 1 : 0);
      step();
    end
    chk("fill_free_count", free_count, 0);
    chk("fill_queue_full", queue_full, 1);

    // Accept at full while allocating: freed slot reusable next cycle
    alloc_req = 1'b0; ready_vec = 16'h0080; exe_ready = 1'b0;
    step();
    chk("full_issue_valid", issue_valid, 1);
    chk("full_issue_idx", issue_idx, 7);
    exe_ready = 1'b1; alloc_req = 1'b1;
    #1;
    chk("full_alloc_ack_blocked", alloc_ack, 0);
    step();
    chk("full_free_after_accept", free_count, 1);
    chk("full_idle_after_accept", issue_valid, 0);
    exe_ready = 1'b0; ready_vec = '0; alloc_req = 1'b1;
    #1;
    chk("full_realloc_idx", alloc_idx, 7);
    chk("full_realloc_ack", alloc_ack, 1);
    step();
    chk("full_refill_count", free_count, 0);
    chk("full_refill_full", queue_full, 1);
    alloc_req = 1'b0;

    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    #1;
    chk("clean_flush_count", free_count, 16);
    chk("clean_flush_empty", queue_empty, 1);

    // Age ordering
    alloc_req = 1'b1;
    step(4);
    alloc_req = 1'b0; ready_vec = 16'h0002; exe_ready = 1'b1;
    step();
    chk("age_first_idx", issue_idx, 1);
    chk("age_first_valid", issue_valid, 1);
    step();
    chk("age_after_free_valid", issue_valid, 0);
    chk("age_after_free_count", free_count, 13);
    ready_vec = '0; exe_ready = 1'b0; alloc_req = 1'b1;
    #1;
    chk("age_realloc_idx", alloc_idx, 1);
    step();
    alloc_req = 1'b0; ready_vec = 16'h000F; exe_ready = 1'b1;
    step(); chk("age_order0", issue_idx, 0);
    step(); chk("age_order1", issue_idx, 2);
    step(); chk("age_order2", issue_idx, 3);
    step(); chk("age_order3", issue_idx, 1);
    step();
    chk("age_drained_valid", issue_valid, 0);
    chk("age_drained_count", free_count, 16);
    ready_vec = '0; exe_ready = 1'b0;

    // Backpressure without preemption, then stall
    alloc_req = 1'b1;
    step(6);
    alloc_req = 1'b0; ready_vec = 16'h0020;
    step();
    chk("bp_offer_idx", issue_idx, 5);
    ready_vec = 16'h0024;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_idx", issue_idx, 5);
      chk("bp_hold_valid", issue_valid, 1);
    end
    exe_ready = 1'b1;
    step();
    chk("bp_next_idx", issue_idx, 2);
    chk("bp_count", free_count, 11);
    STALL = 1'b1; alloc_req = 1'b1;
    #1;
    chk("stall_alloc_ack", alloc_ack, 0);
    step(2);
    chk("stall_issue_idx", issue_idx, 2);
    chk("stall_issue_valid", issue_valid, 1);
    chk("stall_count", free_count, 11);
    STALL = 1'b0; alloc_req = 1'b0;
    step();
    chk("unstall_valid", issue_valid, 0);
    chk("unstall_count", free_count, 12);
    ready_vec = '0; exe_ready = 1'b0;

    // Flush with an active offer and pending alloc/accept
    alloc_req = 1'b1;
    step(4);
    alloc_req = 1'b0;
    chk("fl_count_before", free_count, 8);
    ready_vec = 16'h0001;
    step();
    chk("fl_offer_idx", issue_idx, 0);
    FLUSH = 1'b1; exe_ready = 1'b1; alloc_req = 1'b1;
    #1;
    chk("fl_alloc_ack", alloc_ack, 0);
    step();
    FLUSH = 1'b0; exe_ready = 1'b0; alloc_req = 1'b0; ready_vec = '0;
    #1;
    chk("fl_issue_valid", issue_valid, 0);
    chk("fl_free_count", free_count, 16);
    chk("fl_alloc_idx", alloc_idx, 0);

    // Asynchronous reset in mid-operation
    alloc_req = 1'b1;
    step(3);
    alloc_req = 1'b0; ready_vec = 16'h0001;
    step();
    chk("ar_offer_valid", issue_valid, 1);
    #3;
    RESET = 1'b0;
    #1;
    chk("ar_free_count", free_count, 16);
    chk("ar_issue_valid", issue_valid, 0);
    chk("ar_queue_empty", queue_empty, 1);
    ready_vec = '0;
    step(2);
    RESET = 1'b1;
    step(2);
    chk("ar_after_release", free_count, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
